// File: rtl/hex_uart_sender_pkg.sv
// Shared types and constants for the hex UART sender: FSM state encoding,
// line-ending characters and message-length helper.
package hex_uart_sender_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    NEXT_CHAR = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic int unsigned total_chars(input int unsigned nchars,
                                              input int unsigned send_crlf);
    return nchars + 2 * send_crlf;
  endfunction

endpackage

// File: rtl/hex_uart_sender_if.sv
// Request/status bundle between a producer of packed ASCII words and the
// hex UART sender; the serial line travels with it.
interface hex_uart_sender_if;

  logic [31:0] ascii_in;
  logic        start;
  logic        busy;
  logic        done;
  logic        tx;

  modport master (output ascii_in, output start,
                  input  busy, input done, input tx);

  modport slave  (input  ascii_in, input start,
                  output busy, output done, output tx);

endinterface

// File: rtl/hex_uart_sender.sv
// Serialises a latched word of ASCII characters (MSB character first, plus
// optional CR/LF) as 8N1 UART frames; tx trails the FSM state by one register.
module hex_uart_sender
  import hex_uart_sender_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned NCHARS       = 4,
  parameter int unsigned SEND_CRLF    = 1
) (
  input  logic              clk,
  input  logic              rst,
  hex_uart_sender_if.slave  bus
);

  localparam int unsigned TOTAL = total_chars(NCHARS, SEND_CRLF);
  localparam int unsigned MW    = 8 * TOTAL;
  localparam int unsigned CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_CHAR = 3'(TOTAL - 1);

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [2:0]      bit_idx, bit_next;
  logic [2:0]      char_idx, char_next;
  logic [MW-1:0]   msg, msg_next;
  logic [MW-1:0]   msg_load;
  logic [7:0]      cur_byte;
  logic            bit_done;
  logic            tx, tx_next;
  logic            busy, busy_next;
  logic            done, done_next;

  // The whole message, line ending included, is one shift register: the
  // character on the wire is always the top byte.
  generate
    if (SEND_CRLF != 0) begin : g_crlf
      assign msg_load = {bus.ascii_in[8*NCHARS-1:0], ASCII_CR, ASCII_LF};
    end else begin : g_plain
      assign msg_load = bus.ascii_in[8*NCHARS-1:0];
    end
  endgenerate

  assign cur_byte = msg[MW-1 -: 8];
  assign bit_done = (cnt == CNT_MAX);
  assign bus.tx   = tx;
  assign bus.busy = busy;
  assign bus.done = done;

  // State, counters, message register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= 3'd0;
      char_idx <= 3'd0;
      msg      <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      bit_idx  <= bit_next;
      char_idx <= char_next;
      msg      <= msg_next;
      tx       <= tx_next;
      busy     <= busy_next;
      done     <= done_next;
    end
  end

  // Next-state and next-output logic; tx_next reflects the current state.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_idx;
    char_next  = char_idx;
    msg_next   = msg;
    busy_next  = busy;
    done_next  = 1'b0;
    tx_next    = 1'b1;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (bus.start) begin
          state_next = START_BIT;
          msg_next   = msg_load;
          char_next  = 3'd0;
          bit_next   = 3'd0;
          cnt_next   = '0;
          busy_next  = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      START_BIT: begin
        tx_next = 1'b0;
        if (bit_done) begin
          state_next = DATA_BITS;
          cnt_next   = '0;
          bit_next   = 3'd0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      DATA_BITS: begin
        tx_next = cur_byte[bit_idx];
        if (bit_done) begin
          cnt_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = STOP_BIT;
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      STOP_BIT: begin
        tx_next = 1'b1;
        if (bit_done) begin
          state_next = NEXT_CHAR;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      NEXT_CHAR: begin
        tx_next  = 1'b1;
        cnt_next = '0;
        if (char_idx == LAST_CHAR) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else begin
          state_next = START_BIT;
          char_next  = char_idx + 3'd1;
          msg_next   = msg << 4'd8;
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/hex_uart_sender.md
Name: hex_uart_sender

Overview:
- Downstream consumer of the binary-to-ASCII hex converter.
- Accepts a 32-bit word of four ASCII hex characters and transmits them as 8N1 UART serial output, most significant character first.
- Optionally appends CR/LF after the characters.
- Used to stream keyboard scan codes to a host terminal for debug.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); minimum 2.
- NCHARS, 4, ASCII characters taken from ascii_in, from ascii_in[8*NCHARS-1 -: 8] down to ascii_in[7:0].
- SEND_CRLF, 1, when 1 append 8'h0D then 8'h0A after the last character.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- ascii_in  input  32  packed ASCII characters; byte 3 is sent first.
- start  input  1  request strobe, sampled each cycle.
- busy  output  1  high while a message is in progress.
- done  output  1  one-cycle pulse after the final stop bit completes.
- tx  output  1  UART serial line; idles high.

Behaviour:
- Reset (rst=1 at a rising edge): on that edge, tx=1, busy=0, done=0, FSM=IDLE, and all counters and shift register are cleared. This applies mid-frame: the line returns high immediately, with no partial-frame completion.
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT, NEXT_CHAR.
- IDLE:
  - tx=1.
  - When start=1 at edge N, the following happen at edge N: latch ascii_in into the message register, set char_idx=0, set busy=1, go to START_BIT.
  - tx drives 0 from edge N+1 onward; that is one cycle of latency from the sampled start.
- START_BIT: tx=0 for CLKS_PER_BIT cycles, then go to DATA_BITS with bit_idx=0.
- DATA_BITS:
  - tx = current byte bit bit_idx, LSB first, each bit held CLKS_PER_BIT cycles.
  - After bit 7, go to STOP_BIT.
- STOP_BIT: tx=1 for CLKS_PER_BIT cycles, then go to NEXT_CHAR.
- NEXT_CHAR (one cycle, tx=1):
  - If more characters remain, increment char_idx and go to START_BIT.
  - Otherwise go to IDLE, clear busy and pulse done for exactly one cycle.
- Character sequence:
  - Bytes NCHARS-1 down to 0 of the latched word.
  - Then, if SEND_CRLF=1, 8'h0D and 8'h0A.
  - Total characters per message: NCHARS + 2*SEND_CRLF.
- Frame timing: each character occupies 10*CLKS_PER_BIT cycles plus 1 NEXT_CHAR cycle. With defaults, busy stays high for 6*(10*868+1) = 52086 cycles.
- Baud counter:
  - Width clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit.
  - Reset to 0 on every state entry.
- start while busy=1: ignored. No queueing; ascii_in changes during transmission have no effect.
- start on the same edge that done is asserted: ignored. A new message may begin on the next cycle (IDLE with start=1).
- start and rst together: rst wins.
- done and busy are never both 1.
- ascii_in content is not validated; any byte value is sent verbatim.

Decomposition:
- Shared package holds:
  - FSM state typedef (IDLE, START_BIT, DATA_BITS, STOP_BIT, NEXT_CHAR).
  - Constants ASCII_CR=8'h0D and ASCII_LF=8'h0A.
- Natural sub-module: uart_tx_byte.
  - Single 8N1 byte transmitter with byte_in, send, tx, and a tx_done pulse.
  - The top level is then a character sequencer (IDLE / SEND / WAIT / NEXT) driving it.
  - Cycle timing must match the Behaviour section either way.

Test Plan:
- Reset mid-frame: with CLKS_PER_BIT=4, start then rst=1 at cycle 15 → tx=1, busy=0, done=0 on the next edge; no further activity until a new start.
- Basic message: CLKS_PER_BIT=4, SEND_CRLF=1, ascii_in=32'h3141_3046 ("1A0F"), start pulsed once.
  - tx falls exactly 1 cycle after the start edge.
  - Decoded bytes are 0x31, 0x41, 0x30, 0x46, 0x0D, 0x0A.
  - Each bit is 4 cycles wide.
  - done pulses once, 6*41=246 cycles after busy rises.
- No CRLF: SEND_CRLF=0, ascii_in=32'h4646_3030 → exactly 4 bytes 0x46, 0x46, 0x30, 0x30; busy high 164 cycles.
- Start while busy: pulse start again mid-message with a different ascii_in (32'h3939_3939) → ignored; original bytes sent; single done.
- Back-to-back: assert start the cycle after done → the second message starts with tx low 1 cycle later. Bytes of both messages are correct and there is no extra idle bit beyond the stop bit.
- Idle line check: after reset with no start for 1000 cycles → tx constantly 1, busy=0, done never asserted.
